// File: rtl/ramb16_s4_byte_port.sv
// Byte-wide initiator for one S4 (4-bit x 4096) block RAM port: each byte
// request becomes two nibble accesses. Optional write ack: RAMB16_S4_BYTE_PORT_WR_ACK_EN.
module ramb16_s4_byte_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [10:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [7:0]  rsp_rdata,
   output logic [11:0] ram_addr,
   output logic [3:0]  ram_di,
   output logic        ram_en,
   output logic        ram_we,
   output logic        ram_ssr,
   input  logic [3:0]  ram_do
);

   localparam int unsigned BYTE_AW = 11;
   localparam int unsigned NIB_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      WR_LO,
      WR_HI,
      RD_LO,
      RD_HI,
      RD_CAP,
      RSP
   } state_t;

   state_t               state;
   logic [BYTE_AW-1:0]   addr_q;
   logic [NIB_W-1:0]     wdata_hi_q;
   logic [NIB_W-1:0]     rdata_lo_q;

   assign ram_ssr = 1'b0;

   // Sequencer; RAM strobes are loaded one edge ahead so they line up with the state they belong to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         wdata_hi_q <= '0;
         rdata_lo_q <= '0;
         req_ready  <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         ram_addr   <= '0;
         ram_di     <= '0;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q     <= req_addr;
                  wdata_hi_q <= req_wdata[7:4];
                  req_ready  <= 1'b0;
                  ram_en     <= 1'b1;
                  ram_addr   <= {req_addr, 1'b0};
                  if (req_we) begin
                     state  <= WR_LO;
                     ram_we <= 1'b1;
                     ram_di <= req_wdata[3:0];
                  end else begin
                     state  <= RD_LO;
                     ram_we <= 1'b0;
                     ram_di <= '0;
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            WR_LO: begin
               state    <= WR_HI;
               ram_addr <= {addr_q, 1'b1};
               ram_di   <= wdata_hi_q;
            end
            WR_HI: begin
               ram_en <= 1'b0;
               ram_we <= 1'b0;
               ram_di <= '0;
`ifdef RAMB16_S4_BYTE_PORT_WR_ACK_EN
               state     <= RSP;
               rsp_valid <= 1'b1;
               rsp_rdata <= '0;
`else
               state     <= IDLE;
               req_ready <= 1'b1;
`endif
            end
            RD_LO: begin
               state    <= RD_HI;
               ram_addr <= {addr_q, 1'b1};
            end
            RD_HI: begin
               // RAM output register holds the low nibble during this state
               rdata_lo_q <= ram_do;
               ram_en     <= 1'b0;
               state      <= RD_CAP;
            end
            RD_CAP: begin
               rsp_rdata <= {ram_do, rdata_lo_q};
               rsp_valid <= 1'b1;
               state     <= RSP;
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
               ram_en    <= 1'b0;
               ram_we    <= 1'b0;
               ram_di    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ramb16_s4_byte_port.sv
// Directed bench for ramb16_s4_byte_port with a registered-output 4x4096 RAM model.
module tb_ramb16_s4_byte_port;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [10:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_rdata;
   logic [11:0] ram_addr;
   logic [3:0]  ram_di;
   logic        ram_en;
   logic        ram_we;
   logic        ram_ssr;
   logic [3:0]  ram_do;

   logic [3:0]  mem [4096];

   int checks = 0;
   int errors = 0;

   ramb16_s4_byte_port dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_addr  (ram_addr),
      .ram_di    (ram_di),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_ssr   (ram_ssr),
      .ram_do    (ram_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first RAM port with registered output
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_di;
         ram_do <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request that is accepted on the next edge; returns in cycle 1
   task automatic issue(input logic we, input logic [10:0] a, input logic [7:0] d);
      chk("ready_before_accept", 12'(req_ready), 12'h1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      tick();
      req_valid = 1'b0;
      req_wdata = 8'hFF;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_en"},    12'(ram_en),    12'h0);
      chk({tag, "_we"},    12'(ram_we),    12'h0);
      chk({tag, "_addr"},  ram_addr,       12'h000);
      chk({tag, "_di"},    12'(ram_di),    12'h0);
      chk({tag, "_ready"}, 12'(req_ready), 12'h0);
      chk({tag, "_rspv"},  12'(rsp_valid), 12'h0);
      chk({tag, "_rdata"}, 12'(rsp_rdata), 12'h00);
      chk({tag, "_ssr"},   12'(ram_ssr),   12'h0);
   endtask

   task automatic do_write(input logic [10:0] a, input logic [7:0] d, input string tag);
      issue(1'b1, a, d);
      chk({tag, "_c1_en"},   12'(ram_en),   12'h1);
      chk({tag, "_c1_we"},   12'(ram_we),   12'h1);
      chk({tag, "_c1_addr"}, ram_addr,      {a, 1'b0});
      chk({tag, "_c1_di"},   12'(ram_di),   12'(d[3:0]));
      chk({tag, "_c1_rdy"},  12'(req_ready), 12'h0);
      tick();
      chk({tag, "_c2_we"},   12'(ram_we),   12'h1);
      chk({tag, "_c2_addr"}, ram_addr,      {a, 1'b1});
      chk({tag, "_c2_di"},   12'(ram_di),   12'(d[7:4]));
      tick();
      chk({tag, "_c3_en"},   12'(ram_en),   12'h0);
      chk({tag, "_c3_we"},   12'(ram_we),   12'h0);
`ifdef RAMB16_S4_BYTE_PORT_WR_ACK_EN
      chk({tag, "_c3_ack"},   12'(rsp_valid), 12'h1);
      chk({tag, "_c3_ackd"},  12'(rsp_rdata), 12'h00);
      chk({tag, "_c3_rdy"},   12'(req_ready), 12'h0);
      rsp_ready = 1'b1;
      tick();
      chk({tag, "_c4_rdy"},   12'(req_ready), 12'h1);
      chk({tag, "_c4_rspv"},  12'(rsp_valid), 12'h0);
`else
      chk({tag, "_c3_rdy"},  12'(req_ready), 12'h1);
      chk({tag, "_c3_rspv"}, 12'(rsp_valid), 12'h0);
`endif
      chk({tag, "_mem_lo"}, 12'(mem[{a, 1'b0}]), 12'(d[3:0]));
      chk({tag, "_mem_hi"}, 12'(mem[{a, 1'b1}]), 12'(d[7:4]));
   endtask

   task automatic do_read(input logic [10:0] a, input logic [7:0] exp, input string tag);
      rsp_ready = 1'b1;
      issue(1'b0, a, 8'h00);
      chk({tag, "_c1_en"},   12'(ram_en),   12'h1);
      chk({tag, "_c1_we"},   12'(ram_we),   12'h0);
      chk({tag, "_c1_addr"}, ram_addr,      {a, 1'b0});
      tick();
      chk({tag, "_c2_we"},   12'(ram_we),   12'h0);
      chk({tag, "_c2_addr"}, ram_addr,      {a, 1'b1});
      tick();
      chk({tag, "_c3_en"},   12'(ram_en),   12'h0);
      chk({tag, "_c3_rspv"}, 12'(rsp_valid), 12'h0);
      tick();
      chk({tag, "_c4_rspv"}, 12'(rsp_valid), 12'h1);
      chk({tag, "_c4_data"}, 12'(rsp_rdata), 12'(exp));
      chk({tag, "_c4_rdy"},  12'(req_ready), 12'h0);
      tick();
      chk({tag, "_c5_rdy"},  12'(req_ready), 12'h1);
      chk({tag, "_c5_rspv"}, 12'(rsp_valid), 12'h0);
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;

      // Reset values
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();
      chk("ready_after_release", 12'(req_ready), 12'h1);

      do_write(11'h003, 8'hA5, "wr003");
      do_read(11'h003, 8'hA5, "rd003");

      // Held response under backpressure
      rsp_ready = 1'b0;
      issue(1'b0, 11'h003, 8'h00);
      tick();
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("bp_rspv",  12'(rsp_valid), 12'h1);
         chk("bp_data",  12'(rsp_rdata), 12'h0A5);
         chk("bp_rdy",   12'(req_ready), 12'h0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_done_rspv", 12'(rsp_valid), 12'h0);
      chk("bp_done_rdy",  12'(req_ready), 12'h1);

      // Top byte address
      do_write(11'h7FF, 8'h3C, "wr7ff");
      do_read(11'h7FF, 8'h3C, "rd7ff");

      // Reset in WR_HI
      issue(1'b1, 11'h010, 8'h5A);
      tick();
      chk("wrhi_we", 12'(ram_we), 12'h1);
      rst = 1'b1;
      #1;
      check_all_zero("rst_wrhi");
      tick();
      rst = 1'b0;
      tick();
      chk("rst_wrhi_rdy", 12'(req_ready), 12'h1);
      chk("rst_wrhi_mem_lo", 12'(mem[12'h020]), 12'hA);

      // Reset in RD_HI
      issue(1'b0, 11'h003, 8'h00);
      tick();
      chk("rdhi_addr", ram_addr, 12'h007);
      rst = 1'b1;
      #1;
      check_all_zero("rst_rdhi");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rst_rdhi_no_rsp", 12'(rsp_valid), 12'h0);
         chk("rst_rdhi_rdy",    12'(req_ready), 12'h1);
      end

      // Write response behaviour depends on build option
      do_write(11'h100, 8'h11, "wr100");
      do_read(11'h100, 8'h11, "rd100");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
